// File: rtl/sdram_arbiter.sv
// sdram_arbiter: three-port round-robin arbiter in front of a single SDRAM
// controller command port. One access in flight at a time; each access is
// held until the controller acks or the timeout counter expires.

// Per-port request decode: a port is pending on read or write; write wins
// when both are set, so an illegal read+write becomes a single write.
module sdram_arbiter_port (
    input  logic rd,
    input  logic wr,
    output logic pend,
    output logic is_wr
);
    assign pend  = rd | wr;
    assign is_wr = wr;
endmodule

module sdram_arbiter #(
    parameter int ADRS_W  = 25,
    parameter int TIMEOUT = 1023
) (
    input  logic                  m_clock,
    input  logic                  p_reset_n,
    input  logic [2:0]            req_read,
    input  logic [2:0]            req_write,
    input  logic [3*ADRS_W-1:0]   req_adrs,
    input  logic [95:0]           req_wdata,
    input  logic [11:0]           req_de,
    output logic [2:0]            req_ack,
    output logic [2:0]            req_err,
    output logic [31:0]           req_rdata,
    output logic                  sdram_read,
    output logic                  sdram_write,
    output logic [ADRS_W-1:0]     sdram_adrs,
    output logic [31:0]           sdram_wdata,
    output logic [3:0]            sdram_de,
    input  logic [31:0]           sdram_rdata,
    input  logic                  sdram_ack,
    input  logic                  sdram_refresh_doing,
    output logic                  busy
);
    localparam int NUM_PORTS = 3;
    localparam logic [9:0] TO_MAX = 10'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADRS_W-1:0] adrs;
        logic [31:0]       wdata;
        logic [3:0]        de;
    } cmd_t;

    state_t state, nxt_state;
    logic [1:0]  last;
    logic [9:0]  cnt;
    logic        err_flag;
    logic [31:0] rdata_q;
    cmd_t        cmd_q;

    logic [NUM_PORTS-1:0]             pend;
    logic [NUM_PORTS-1:0]             is_wr;
    logic [NUM_PORTS-1:0][ADRS_W-1:0] p_adrs;
    logic [NUM_PORTS-1:0][31:0]       p_wdata;
    logic [NUM_PORTS-1:0][3:0]        p_de;

    logic       grant_vld;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       take;
    logic       timed_out;

    // Flat port buses viewed as per-port packed arrays
    assign p_adrs  = req_adrs;
    assign p_wdata = req_wdata;
    assign p_de    = req_de;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        sdram_arbiter_port u_port (
            .rd    (req_read[i]),
            .wr    (req_write[i]),
            .pend  (pend[i]),
            .is_wr (is_wr[i])
        );
    end

    // Round-robin pick: first pending port scanning last+1, last+2, last
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last;
        cand      = last;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!grant_vld && pend[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // A grant is only taken from IDLE and never while the controller refreshes
    assign take      = (state == IDLE) && grant_vld && !sdram_refresh_doing;
    assign timed_out = (cnt == TO_MAX);

    // State register
    always_ff @(posedge m_clock or negedge p_reset_n) begin
        if (!p_reset_n) state <= IDLE;
        else            state <= nxt_state;
    end

    // Next-state: ack beats a same-cycle timeout
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (take) nxt_state = ISSUE;
            ISSUE:   if (sdram_ack || timed_out) nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Datapath: latch the granted command, run the timeout, capture read data
    always_ff @(posedge m_clock or negedge p_reset_n) begin
        if (!p_reset_n) begin
            last     <= 2'd2;
            cmd_q    <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        last        <= grant_idx;
                        cmd_q.wr    <= is_wr[grant_idx];
                        cmd_q.adrs  <= p_adrs[grant_idx];
                        cmd_q.wdata <= p_wdata[grant_idx];
                        cmd_q.de    <= p_de[grant_idx];
                        cnt         <= '0;
                        err_flag    <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (sdram_ack) begin
                        rdata_q <= sdram_rdata;
                    end else if (timed_out) begin
                        err_flag <= 1'b1;
                        rdata_q  <= '0;
                    end else if (cnt != 10'h3FF) begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: command level in ISSUE, one-cycle ack/err/rdata in DONE
    always_comb begin
        sdram_read  = 1'b0;
        sdram_write = 1'b0;
        req_ack     = '0;
        req_err     = '0;
        req_rdata   = '0;
        busy        = 1'b0;
        case (state)
            ISSUE: begin
                busy        = 1'b1;
                sdram_write = cmd_q.wr;
                sdram_read  = !cmd_q.wr;
            end
            DONE: begin
                busy          = 1'b1;
                req_ack[last] = 1'b1;
                req_err[last] = err_flag;
                req_rdata     = rdata_q;
            end
            default: ;
        endcase
    end

    assign sdram_adrs  = cmd_q.adrs;
    assign sdram_wdata = cmd_q.wdata;
    assign sdram_de    = cmd_q.de;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench. Expected commands and responses are
// queued when a request is driven and popped when the DUT issues/acks.
module tb_sdram_arbiter;
    localparam int AW = 25;
    localparam int TO = 15;

    logic            m_clock = 1'b0;
    logic            p_reset_n = 1'b1;
    logic [2:0]      req_read = '0, req_write = '0;
    logic [3*AW-1:0] req_adrs = '0;
    logic [95:0]     req_wdata = '0;
    logic [11:0]     req_de = '0;
    logic [2:0]      req_ack, req_err;
    logic [31:0]     req_rdata;
    logic            sdram_read, sdram_write;
    logic [AW-1:0]   sdram_adrs;
    logic [31:0]     sdram_wdata;
    logic [3:0]      sdram_de;
    logic [31:0]     sdram_rdata = '0;
    logic            sdram_ack = 1'b0;
    logic            sdram_refresh_doing = 1'b0;
    logic            busy;

    sdram_arbiter #(.ADRS_W(AW), .TIMEOUT(TO)) dut (
        .m_clock(m_clock), .p_reset_n(p_reset_n),
        .req_read(req_read), .req_write(req_write), .req_adrs(req_adrs),
        .req_wdata(req_wdata), .req_de(req_de),
        .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
        .sdram_read(sdram_read), .sdram_write(sdram_write),
        .sdram_adrs(sdram_adrs), .sdram_wdata(sdram_wdata), .sdram_de(sdram_de),
        .sdram_rdata(sdram_rdata), .sdram_ack(sdram_ack),
        .sdram_refresh_doing(sdram_refresh_doing), .busy(busy)
    );

    always #5 m_clock = ~m_clock;

    typedef struct {
        logic          rd, wr;
        logic [AW-1:0] adrs;
        logic [31:0]   wdata;
        logic [3:0]    de;
    } cmd_t;
    typedef struct {
        logic [2:0]  ack, err;
        logic [31:0] rdata;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t mon_c;
    rsp_t mon_r;
    logic mon_cmd;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int run_len = 0, last_len = 0, rise_cyc = -1;
    int ctl_delay = 0, ctl_cnt = 0;
    bit ctl_on = 1'b1, stray_req = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_cmd(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] de);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.adrs = a; c.wdata = d; c.de = de;
        cmd_q.push_back(c);
    endtask

    task automatic exp_rsp(input logic [2:0] ack, input logic [2:0] err, input logic [31:0] rd);
        rsp_t r;
        r.ack = ack; r.err = err; r.rdata = rd;
        rsp_q.push_back(r);
    endtask

    task automatic set_port(input int i, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] de);
        req_read[i]          = rd;
        req_write[i]         = wr;
        req_adrs[i*AW +: AW] = a;
        req_wdata[i*32 +: 32] = d;
        req_de[i*4 +: 4]     = de;
    endtask

    task automatic do_reset();
        p_reset_n = 1'b0;
        req_read = '0; req_write = '0;
        sdram_refresh_doing = 1'b0;
        ctl_on = 1'b1;
        repeat (2) @(negedge m_clock);
        p_reset_n = 1'b1;
        @(negedge m_clock);
    endtask

    // Wait for n acks; optionally drop each acked port's request (requester rule)
    task automatic wait_acks(input int n, input bit drop_each, input int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            @(negedge m_clock);
            t++;
            if (req_ack != 0) begin
                got++;
                if (drop_each)
                    for (int i = 0; i < 3; i++)
                        if (req_ack[i]) begin req_read[i] = 1'b0; req_write[i] = 1'b0; end
            end
        end
        if (got < n) chk("ack_wait_expired", got, n);
    endtask

    always @(posedge m_clock) cyc <= cyc + 1;

    // Controller model: ack ctl_delay cycles after command first seen
    always @(negedge m_clock) begin
        if (stray_req) begin
            sdram_ack = 1'b1;
            stray_req = 1'b0;
        end else if (ctl_on && (sdram_read || sdram_write)) begin
            sdram_ack = (ctl_cnt == ctl_delay);
            ctl_cnt++;
        end else begin
            sdram_ack = 1'b0;
            if (!(sdram_read || sdram_write)) ctl_cnt = 0;
        end
    end

    // Monitor: check command fields on rise, responses on ack
    always @(negedge m_clock) begin
        mon_cmd = sdram_read | sdram_write;
        if (mon_cmd) begin
            if (run_len == 0) begin
                rise_cyc = cyc;
                if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
                else begin
                    mon_c = cmd_q.pop_front();
                    chk("cmd_read", sdram_read, mon_c.rd);
                    chk("cmd_write", sdram_write, mon_c.wr);
                    chk("cmd_adrs", sdram_adrs, mon_c.adrs);
                    chk("cmd_wdata", sdram_wdata, mon_c.wdata);
                    chk("cmd_de", sdram_de, mon_c.de);
                end
            end
            run_len++;
        end else if (run_len != 0) begin
            last_len = run_len;
            run_len  = 0;
        end
        if (req_ack != 0) begin
            if (rsp_q.size() == 0) chk("ack_unexpected", req_ack, 0);
            else begin
                mon_r = rsp_q.pop_front();
                chk("rsp_ack", req_ack, mon_r.ack);
                chk("rsp_err", req_err, mon_r.err);
                chk("rsp_rdata", req_rdata, mon_r.rdata);
            end
        end else if (req_err != 0) begin
            chk("err_without_ack", req_err, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, hits, seen, t;
        // Reset state
        #1 p_reset_n = 1'b0;
        #2;
        chk("rst_ack", req_ack, 0);
        chk("rst_err", req_err, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_cmd", {sdram_read, sdram_write}, 0);
        chk("rst_fields", {sdram_adrs, sdram_wdata, sdram_de}, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // Single read, port 1, ack 4 cycles after command
        ctl_delay = 4;
        sdram_rdata = 32'hDEADBEEF;
        exp_cmd(1, 0, 25'h100, 32'h0, 4'hF);
        exp_rsp(3'b010, 3'b000, 32'hDEADBEEF);
        t0 = cyc;
        set_port(1, 1, 0, 25'h100, 32'h0, 4'hF);
        wait_acks(1, 1, 50);
        @(negedge m_clock);
        chk("t1_cmd_len", last_len, 5);
        chk("t1_latency", rise_cyc, t0 + 1);

        // Three ports writing continuously: 0,1,2,0,1,2
        do_reset();
        ctl_delay = 1;
        sdram_rdata = 32'h55;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++) begin
                exp_cmd(0, 1, 25'h1000 + 25'(i), 32'hA000_0000 | 32'(i * 32'h111), 4'(8 | (1 << i)));
                exp_rsp(3'(1 << i), 3'b000, 32'h55);
            end
        for (int i = 0; i < 3; i++)
            set_port(i, 0, 1, 25'h1000 + 25'(i), 32'hA000_0000 | 32'(i * 32'h111), 4'(8 | (1 << i)));
        wait_acks(6, 0, 200);
        req_write = '0;
        repeat (5) @(negedge m_clock);

        // Refresh blocks the grant for 20 cycles
        do_reset();
        ctl_delay = 2;
        sdram_rdata = 32'hCAFE0002;
        sdram_refresh_doing = 1'b1;
        exp_cmd(1, 0, 25'h1ABCDEF, 32'h0, 4'h5);
        exp_rsp(3'b100, 3'b000, 32'hCAFE0002);
        set_port(2, 1, 0, 25'h1ABCDEF, 32'h0, 4'h5);
        hits = 0;
        repeat (20) begin
            @(negedge m_clock);
            if (sdram_read || sdram_write) hits++;
        end
        chk("t3_no_cmd_in_refresh", hits, 0);
        chk("t3_idle_busy", busy, 0);
        t0 = cyc;
        sdram_refresh_doing = 1'b0;
        wait_acks(1, 1, 50);
        chk("t3_latency", rise_cyc, t0 + 1);

        // Timeout: controller never acks
        do_reset();
        ctl_on = 1'b0;
        sdram_rdata = 32'h12345678;
        exp_cmd(1, 0, 25'h2222, 32'h0, 4'hF);
        exp_rsp(3'b001, 3'b001, 32'h0);
        set_port(0, 1, 0, 25'h2222, 32'h0, 4'hF);
        wait_acks(1, 1, 100);
        @(negedge m_clock);
        chk("t4_cmd_len", last_len, TO + 1);
        stray_req = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge m_clock);
            if (req_ack != 0) seen++;
        end
        chk("t4_stray_ignored", seen, 0);
        chk("t4_busy", busy, 0);

        // Read and write together: one write with de 0011
        do_reset();
        ctl_delay = 0;
        sdram_rdata = 32'h77;
        exp_cmd(0, 1, 25'h33, 32'hFEEDF00D, 4'b0011);
        exp_rsp(3'b001, 3'b000, 32'h77);
        set_port(0, 1, 1, 25'h33, 32'hFEEDF00D, 4'b0011);
        wait_acks(1, 1, 50);
        repeat (5) @(negedge m_clock);
        chk("t5_cmd_len", last_len, 1);

        // Reset during ISSUE drops the command; port 0 first afterwards
        do_reset();
        ctl_on = 1'b0;
        exp_cmd(1, 0, 25'h44, 32'h0, 4'hF);
        set_port(1, 1, 0, 25'h44, 32'h0, 4'hF);
        t = 0;
        while (!sdram_read && t < 20) begin
            @(negedge m_clock);
            t++;
        end
        chk("t6_issue", sdram_read, 1);
        repeat (3) @(negedge m_clock);
        p_reset_n = 1'b0;
        #1;
        chk("t6_async_drop", {sdram_read, sdram_write}, 0);
        chk("t6_busy", busy, 0);
        req_read = '0;
        repeat (2) @(negedge m_clock);
        p_reset_n = 1'b1;
        @(negedge m_clock);
        ctl_on = 1'b1;
        ctl_delay = 1;
        sdram_rdata = 32'h66;
        for (int i = 0; i < 3; i++) begin
            exp_cmd(1, 0, 25'h50 + 25'(i), 32'h0, 4'hF);
            exp_rsp(3'(1 << i), 3'b000, 32'h66);
        end
        for (int i = 0; i < 3; i++) set_port(i, 1, 0, 25'h50 + 25'(i), 32'h0, 4'hF);
        wait_acks(3, 1, 100);
        repeat (4) @(negedge m_clock);

        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-port round-robin arbiter that shares the single 32-bit SDRAM controller request port (write/read/adrs/wdata/enable, rdata/ack/refresh_doing/err) between PSX requesters: CPU bus, GPU VRAM, and CD/SPU DMA. It sits in the 100 MHz SDRAM clock domain between the requesters and the SDRAM controller. It serialises one access at a time, holds the command until the controller acknowledges, and returns data, ack and a timeout error to the granted port.

## Interface
- ADRS_W, 25, SDRAM word address width
- TIMEOUT, 1023, max cycles a command may wait for sdram_ack before abort (10-bit counter)
- m_clock  in  1  SDRAM-domain clock; all state on rising edge
- p_reset_n  in  1  reset; asynchronous, active-low
- req_read  in  3  per-port read request level, bit i = port i
- req_write  in  3  per-port write request level
- req_adrs  in  3*ADRS_W  port i address at [i*ADRS_W +: ADRS_W]
- req_wdata  in  96  port i write data at [i*32 +: 32]
- req_de  in  12  port i byte enables at [i*4 +: 4]
- req_ack  out  3  one-cycle completion pulse to the granted port
- req_err  out  3  one-cycle timeout pulse, coincident with req_ack
- req_rdata  out  32  read data, valid only in the req_ack cycle
- sdram_read / sdram_write  out  1 each  command levels to the controller
- sdram_adrs  out  ADRS_W; sdram_wdata out 32; sdram_de out 4: latched command fields
- sdram_rdata  in  32; sdram_ack in 1 (one-cycle pulse); sdram_refresh_doing in 1
- busy  out  1  high in ISSUE or DONE

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE:
  - Port i is pending when req_read[i] | req_write[i].
  - If any port is pending and sdram_refresh_doing=0, select the first pending port in round-robin order starting at last+1 (mod 3).
  - On selection, latch adrs, wdata and de; set last=i; enter ISSUE.
  - If refresh_doing=1, stay in IDLE with no grant.
- ISSUE:
  - sdram_write = 1 if the latched request was a write, else sdram_read = 1. The level and all fields stay stable until exit.
  - sdram_ack=1: latch sdram_rdata into req_rdata; enter DONE.
  - Timeout counter reaches TIMEOUT without ack: set the error flag; req_rdata = 0; enter DONE.
- DONE:
  - req_ack[last] = 1; req_err[last] = error flag. Command outputs are 0. Return to IDLE.
- Requester rule: hold req and all fields stable until its req_ack. It may drop or change the request in the cycle after the ack.
- Illegal input, read and write both set on one port: perform the write only and issue one ack.
- refresh_doing rising while in ISSUE has no effect on the arbiter. The command is held, and the controller completes it after refresh.
- A late sdram_ack arriving in IDLE or DONE after a timeout is ignored.
- Requests are not queued. The arbiter never accepts a second grant before DONE.

## Timing
- Reset values (asynchronous, p_reset_n=0):
  - state = IDLE; last = 2, so port 0 wins first.
  - All outputs 0, including sdram_adrs, sdram_wdata, sdram_de and req_rdata.
  - Timeout counter and error flag = 0.
- Reset asserted mid-ISSUE drops the command immediately; no ack is issued.
- Latency:
  - Request sampled in IDLE at cycle N → command asserted at N+1.
  - sdram_ack at cycle M → req_ack at M+1, command deasserted at M+1.
  - Next grant is decided at M+2; the command appears at M+3.
- Minimum spacing of back-to-back accesses: 3 cycles plus controller latency.
- Timeout counter: cleared on entry to ISSUE, incremented each ISSUE cycle without ack. Abort occurs at count == TIMEOUT, i.e. TIMEOUT+1 cycles after the command is asserted.
- Width rules:
  - last is 2 bits; values 0..2 only, wrapping 2 → 0.
  - The counter saturates and never wraps.

## Test plan
- Single read, port 1: adrs=0x0000100, controller acks 4 cycles after the command with rdata=0xDEADBEEF → sdram_read high for 5 cycles, then req_ack=3'b010 and req_rdata=0xDEADBEEF in the same cycle.
- All three ports request writes continuously from reset → grant order 0,1,2,0,1,2. Each sdram_wdata/de matches its port's slice, and each port gets exactly one ack per access.
- refresh_doing=1 for 20 cycles while port 2 requests → no command during refresh. The command is asserted 1 cycle after refresh_doing falls.
- Controller never acks, TIMEOUT=15 → command held 16 cycles, then req_ack[0]=1 and req_err[0]=1 with req_rdata=0. A later stray sdram_ack is ignored.
- Port 0 sets read and write together with de=4'b0011 → one sdram_write with enable 0011, no sdram_read, one ack.
- p_reset_n pulled low during ISSUE → sdram_read/write drop asynchronously, no req_ack. After release, port 0 has first priority.
